oam_dma: RTL and testbench

- Sprite-DMA engine on the 6502 system bus.
- A CPU write to the trigger address starts the transfer. The engine halts the CPU and copies one 256-byte page from memory (ROM/RAM) to the PPU OAM data port.
- It sits directly upstream of the ROM: it drives the ROM's address and active-low output enable, and consumes the byte the ROM returns.
- The top level muxes the bus between the CPU and this block using bus_own, and resolves the inout data tristate into bus_rdata.

---
 rtl/oam_dma_pkg.sv | 23 ++
 rtl/oam_dma.sv | 201 ++++++++++++++++++++
 tb/tb_oam_dma.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
//   Shared types and default constants for the sprite-DMA engine.
//   - dma_state_t      : engine state encoding
//   - TRIGGER_ADDR_DEF : CPU write address that launches a transfer
//   - OAM_PORT_DEF     : PPU OAM data port every byte is written to
//   - PAGE_BYTES_DEF   : bytes copied per transfer (one 6502 page)
// -----------------------------------------------------------------------------
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] TRIGGER_ADDR_DEF = 16'h4014;
    localparam logic [15:0] OAM_PORT_DEF     = 16'h2004;
    localparam int          PAGE_BYTES_DEF   = 256;

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   Sprite-DMA engine for a 6502 system bus. A CPU write of a page number to
//   TRIGGER_ADDR stalls the CPU and copies that 256-byte page, byte by byte,
//   to the PPU OAM data port using alternating READ/WRITE bus cycles. READ
//   cycles always land on an even cycle of the free-running parity flop; an
//   extra ALIGN cycle is inserted when the halt cycle falls on an even cycle.
//
// Optional build macro:
//   OAM_DMA_ABORT_EN - adds the 'abort' input. An abort pulse in any busy state
//                      ends the transfer after the current/next WRITE (or at
//                      once from HALT/ALIGN); a byte is never split.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   cpu_addr   in   [15:0] CPU address bus
//   cpu_wdata  in   [7:0]  CPU write data (source page on a trigger write)
//   cpu_we     in   CPU write strobe
//   abort      in   (OAM_DMA_ABORT_EN only) request early end of transfer
//   cpu_rdy    out  low stalls the CPU
//   dma_busy   out  high while a transfer is in progress
//   bus_own    out  high while this block drives the bus
//   bus_addr   out  [15:0] address to ROM/RAM/PPU
//   bus_oe_n   out  active-low memory read enable
//   bus_we_n   out  active-low write enable
//   bus_rdata  in   [7:0]  memory read data, valid while bus_oe_n=0
//   bus_wdata  out  [7:0]  byte written to the OAM port
// -----------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = TRIGGER_ADDR_DEF,
    parameter logic [15:0] OAM_PORT     = OAM_PORT_DEF,
    parameter int          PAGE_BYTES   = PAGE_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
`ifdef OAM_DMA_ABORT_EN
    input  logic        abort,
`endif
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic        bus_own,
    output logic [15:0] bus_addr,
    output logic        bus_oe_n,
    output logic        bus_we_n,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  bus_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

    dma_state_t  state_reg, state_next;
    logic [7:0]  page_reg, page_next;
    logic [7:0]  idx_reg, idx_next;
    logic        parity_reg;

    logic        cpu_rdy_reg, cpu_rdy_next;
    logic        dma_busy_reg, dma_busy_next;
    logic        bus_own_reg, bus_own_next;
    logic [15:0] bus_addr_reg, bus_addr_next;
    logic        bus_oe_n_reg, bus_oe_n_next;
    logic        bus_we_n_reg, bus_we_n_next;
    logic [7:0]  bus_wdata_reg, bus_wdata_next;

    logic        trigger;
    logic        stop_req;

    assign trigger = cpu_we && (cpu_addr == TRIGGER_ADDR);

`ifdef OAM_DMA_ABORT_EN
    logic abort_flag_reg, abort_flag_next;

    // The flag makes an abort seen during READ still honoured at the
    // following WRITE; the live term lets HALT/ALIGN/WRITE react the same cycle.
    assign stop_req = abort_flag_reg || (abort && (state_reg != IDLE));
`else
    assign stop_req = 1'b0;
`endif

    // Next-state, counters and registered-output values.
    always_comb begin
        state_next = state_reg;
        page_next  = page_reg;
        idx_next   = idx_reg;

        unique case (state_reg)
            IDLE: begin
                if (trigger) begin
                    page_next  = cpu_wdata;
                    idx_next   = '0;
                    state_next = HALT;
                end
            end
            HALT: begin
                // READ must fall on an even parity cycle; the parity flips
                // every clock, so p=1 now means the next cycle is even.
                if (stop_req)
                    state_next = IDLE;
                else if (parity_reg)
                    state_next = READ;
                else
                    state_next = ALIGN;
            end
            ALIGN: begin
                state_next = stop_req ? IDLE : READ;
            end
            READ: begin
                state_next = WRITE;
            end
            WRITE: begin
                if ((idx_reg == LAST_IDX) || stop_req) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else begin
                    idx_next   = idx_reg + 8'd1;
                    state_next = READ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being
        // entered rather than the state being left.
        cpu_rdy_next   = (state_next == IDLE);
        dma_busy_next  = (state_next != IDLE);
        bus_own_next   = (state_next == ALIGN) || (state_next == READ) ||
                         (state_next == WRITE);
        bus_oe_n_next  = (state_next != READ);
        bus_we_n_next  = (state_next != WRITE);

        bus_addr_next  = '0;
        if (state_next == READ)
            bus_addr_next = {page_next, idx_next};
        else if (state_next == WRITE)
            bus_addr_next = OAM_PORT;

        // WRITE is only ever entered from READ, so this edge is the READ
        // capture edge for the byte coming back from memory.
        unique case (state_next)
            WRITE:   bus_wdata_next = bus_rdata;
            IDLE:    bus_wdata_next = '0;
            default: bus_wdata_next = bus_wdata_reg;
        endcase
    end

`ifdef OAM_DMA_ABORT_EN
    always_comb begin
        abort_flag_next = (state_next == IDLE) ? 1'b0 : stop_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            page_reg       <= '0;
            idx_reg        <= '0;
            parity_reg     <= 1'b0;
            cpu_rdy_reg    <= 1'b1;
            dma_busy_reg   <= 1'b0;
            bus_own_reg    <= 1'b0;
            bus_addr_reg   <= '0;
            bus_oe_n_reg   <= 1'b1;
            bus_we_n_reg   <= 1'b1;
            bus_wdata_reg  <= '0;
`ifdef OAM_DMA_ABORT_EN
            abort_flag_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            page_reg       <= page_next;
            idx_reg        <= idx_next;
            parity_reg     <= ~parity_reg;
            cpu_rdy_reg    <= cpu_rdy_next;
            dma_busy_reg   <= dma_busy_next;
            bus_own_reg    <= bus_own_next;
            bus_addr_reg   <= bus_addr_next;
            bus_oe_n_reg   <= bus_oe_n_next;
            bus_we_n_reg   <= bus_we_n_next;
            bus_wdata_reg  <= bus_wdata_next;
`ifdef OAM_DMA_ABORT_EN
            abort_flag_reg <= abort_flag_next;
`endif
        end
    end

    assign cpu_rdy   = cpu_rdy_reg;
    assign dma_busy  = dma_busy_reg;
    assign bus_own   = bus_own_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_oe_n  = bus_oe_n_reg;
    assign bus_we_n  = bus_we_n_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
//   Self-checking bench for oam_dma. A transfer is modelled as a timeline:
//   offset 0 is the halt cycle, an optional align cycle follows, then byte b
//   is read at offset hdr+2b and written at hdr+2b+1. Outputs are compared to
//   that timeline every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
`ifdef OAM_DMA_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        cpu_rdy, dma_busy, bus_own, bus_oe_n, bus_we_n;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rdata, bus_wdata;
    logic [7:0]  junk = 8'h00;
    logic [7:0]  salt = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
`ifdef OAM_DMA_ABORT_EN
        .abort    (abort),
`endif
        .cpu_rdy  (cpu_rdy),
        .dma_busy (dma_busy),
        .bus_own  (bus_own),
        .bus_addr (bus_addr),
        .bus_oe_n (bus_oe_n),
        .bus_we_n (bus_we_n),
        .bus_rdata(bus_rdata),
        .bus_wdata(bus_wdata)
    );

    // Memory contents as a function of address; junk outside read cycles.
    function automatic logic [7:0] rom(input logic [15:0] a);
        return 8'(a[7:0] * 8'd7 + a[15:8] * 8'd13) ^ salt;
    endfunction

    assign bus_rdata = (bus_oe_n == 1'b0) ? rom(bus_addr) : junk;
    always @(negedge clk) junk <= 8'($urandom);

    // ---------------- reference model (updated at each active edge) --------
    bit         started = 1'b0;
    int         cyc = 0;          // cycles since reset; parity = cyc % 2
    bit         m_busy = 1'b0;
    int         m_off = 0;
    int         m_total = 0;
    bit         m_align = 1'b0;
    logic [7:0] m_page = 8'h00;

`ifdef OAM_DMA_ABORT_EN
    function automatic int abort_end(input int o, input bit al);
        int hdr;
        hdr = al ? 2 : 1;
        if (o < hdr) return o + 1;
        return hdr + 2 * ((o - hdr) / 2) + 2;
    endfunction
`endif

    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            cyc     = 0;
            m_busy  = 1'b0;
        end else if (started) begin
            cyc++;
            if (m_busy) begin
`ifdef OAM_DMA_ABORT_EN
                if (abort && abort_end(m_off, m_align) < m_total)
                    m_total = abort_end(m_off, m_align);
`endif
                m_off++;
                if (m_off >= m_total) m_busy = 1'b0;
            end else if (cpu_we && cpu_addr == 16'h4014) begin
                m_busy  = 1'b1;
                m_off   = 0;
                m_page  = cpu_wdata;
                m_align = ((cyc % 2) == 0);   // halt cycle parity is cyc%2
                m_total = m_align ? 514 : 513;
            end
        end
    end

    // ---------------- compare process + bus monitor -------------------------
    logic [28:0] act_v, exp_v, mask_v;
    int          hdr, j, bidx;
    logic [15:0] ea;

    int          stall_run = 0, last_stall = 0, writes_total = 0, odd_reads = 0;
    logic [15:0] last_read = 16'h0, first_read = 16'h0;
    logic [7:0]  rd_and = 8'h00, rd_or = 8'h00;
    bit          first_pending = 1'b0;

    string       d_name = "";
    logic [31:0] d_act = 32'h0, d_exp = 32'h0;
    int          d_seq = 0, d_seen = 0;

    always @(negedge clk) begin
        if (started) begin
            exp_v  = '0;
            mask_v = '0;
            if (!m_busy) begin
                exp_v  = {5'b10011, 16'h0000, 8'h00};
                mask_v = '1;
            end else begin
                hdr = m_align ? 2 : 1;
                mask_v[28:24] = '1;
                if (m_off == 0) begin
                    exp_v[28:24] = 5'b01011;
                end else if (m_off < hdr) begin
                    exp_v[28:24] = 5'b01111;
                end else begin
                    j    = m_off - hdr;
                    bidx = j / 2;
                    ea   = {m_page, 8'(bidx)};
                    if ((j % 2) == 0) begin
                        exp_v[28:24] = 5'b01101;
                        exp_v[23:8]  = ea;
                        mask_v[23:8] = '1;
                    end else begin
                        exp_v[28:24] = 5'b01110;
                        exp_v[23:8]  = 16'h2004;
                        exp_v[7:0]   = rom(ea);
                        mask_v[23:0] = '1;
                    end
                end
            end
            act_v = {cpu_rdy, dma_busy, bus_own, bus_oe_n, bus_we_n, bus_addr, bus_wdata};
            checks++;
            if ((act_v & mask_v) !== (exp_v & mask_v)) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h mask=%h",
                         $time, act_v, exp_v, mask_v);
            end

            if (!cpu_rdy) begin
                if (stall_run == 0) begin
                    rd_and = 8'hFF;
                    rd_or = 8'h00;
                    first_pending = 1'b1;
                end
                stall_run++;
            end else if (stall_run != 0) begin
                last_stall = stall_run;
                stall_run  = 0;
            end
            if (!bus_we_n) writes_total++;
            if (!bus_oe_n) begin
                last_read = bus_addr;
                rd_and = rd_and & bus_addr[15:8];
                rd_or  = rd_or | bus_addr[15:8];
                if (first_pending) begin
                    first_read = bus_addr;
                    first_pending = 1'b0;
                end
                if ((cyc % 2) != 0) odd_reads++;
            end
        end

        if (d_seq != d_seen) begin
            d_seen = d_seq;
            checks++;
            if (d_act !== d_exp) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h", d_name, d_act, d_exp);
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        d_name = name;
        d_act  = a;
        d_exp  = e;
        d_seq++;
        @(negedge clk); #1;
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    // Trigger so that the halt cycle has parity hp.
    task automatic trig(input logic [7:0] pg, input int hp);
        step();
        if ((cyc % 2) == hp) step();
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg;
        step();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        step();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1500; i++) begin
            step();
            if (cpu_rdy === 1'b1 && dma_busy === 1'b0) break;
        end
        check(name, {30'b0, cpu_rdy, dma_busy}, 32'd2);
    endtask

    // Wait for the READ of address a; returns {oe_seen, addr} for checking.
    task automatic wait_read(input logic [15:0] a, output logic [31:0] got);
        got = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (bus_oe_n === 1'b0 && bus_addr === a) begin
                got = {15'b0, 1'b1, bus_addr};
                break;
            end
        end
    endtask

    // ---------------- test sequence ----------------------------------------
    int          w0, odd0;
    logic [31:0] got;
    logic [3:0]  snap;

    initial begin
        salt = 8'($urandom);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        check("reset_state", {27'b0, cpu_rdy, dma_busy, bus_own, bus_oe_n, bus_we_n}, 32'h13);

        // Even-aligned: halt at p=1, no align cycle.
        w0 = writes_total; odd0 = odd_reads;
        trig(8'h02, 1);
        wait_idle("even_done");
        check("even_stall", last_stall, 513);
        check("even_writes", writes_total - w0, 256);
        check("even_first_read", {16'h0, first_read}, 32'h0200);
        check("even_last_read", {16'h0, last_read}, 32'h02FF);

        // Odd-aligned: one align cycle, reads still on even parity.
        w0 = writes_total;
        trig(8'h02, 0);
        wait_idle("odd_done");
        check("odd_stall", last_stall, 514);
        check("odd_writes", writes_total - w0, 256);
        check("odd_reads_at_p1", odd_reads - odd0, 0);

        // Page wrap: page FF stays in FFxx.
        trig(8'hFF, 1);
        wait_idle("wrap_done");
        check("wrap_last_read", {16'h0, last_read}, 32'hFFFF);
        check("wrap_page_and", {24'h0, rd_and}, 32'hFF);
        check("wrap_page_or", {24'h0, rd_or}, 32'hFF);

        // Retrigger while busy is ignored.
        w0 = writes_total;
        trig(8'h02, 1);
        for (int i = 0; i < 200 && (writes_total - w0) < 10; i++) step();
        cpu_write(16'h4014, 8'h05);
        wait_idle("retrig_done");
        check("retrig_page_and", {24'h0, rd_and}, 32'h02);
        check("retrig_page_or", {24'h0, rd_or}, 32'h02);
        check("retrig_last_read", {16'h0, last_read}, 32'h02FF);
        check("retrig_writes", writes_total - w0, 256);

        // Reset mid-transfer at idx 100, then a fresh transfer.
        trig(8'h02, 1);
        wait_read(16'h0264, got);
        reset = 1'b1;
        step();
        snap = {cpu_rdy, bus_own, bus_oe_n, bus_we_n};
        reset = 1'b0;
        check("reset_reached_idx100", got, 32'h0001_0264);
        check("reset_mid_outputs", {28'b0, snap}, 32'hB);
        w0 = writes_total;
        trig(8'h03, 1);
        wait_idle("after_reset_done");
        check("after_reset_first_read", {16'h0, first_read}, 32'h0300);
        check("after_reset_writes", writes_total - w0, 256);

`ifdef OAM_DMA_ABORT_EN
        // Abort during READ of idx 7: that byte completes, then idle.
        w0 = writes_total;
        trig(8'h04, 1);
        wait_read(16'h0407, got);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_idle("abort_done");
        check("abort_reached_idx7", got, 32'h0001_0407);
        check("abort_writes", writes_total - w0, 8);
        check("abort_last_read", {16'h0, last_read}, 32'h0407);
`endif

        // Randomized traffic: stray writes, triggers, rare resets/aborts.
        for (int i = 0; i < 8000; i++) begin
            cpu_we    = ($urandom % 6) == 0;
            cpu_addr  = (($urandom % 3) == 0) ? 16'h4014 : 16'($urandom);
            cpu_wdata = 8'($urandom);
            reset     = ($urandom % 2500) == 0;
`ifdef OAM_DMA_ABORT_EN
            abort     = ($urandom % 500) == 0;
`endif
            step();
        end
        cpu_we = 1'b0; cpu_addr = 16'h0000; reset = 1'b0;
`ifdef OAM_DMA_ABORT_EN
        abort = 1'b0;
`endif
        wait_idle("random_final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
